// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Pipeline hazard unit for a classic 5-stage in-order core with an optional
//   multi-cycle (mul/div) execute stage. Produces the forwarding selects for
//   the E-stage operand muxes, the fetch/decode/execute stall and flush
//   controls, tracks the multi-cycle unit occupancy with a small FSM, and
//   keeps saturating performance counters for decode stalls and decode
//   flushes.
//
// Parameters:
//   AW     - register address width (2^AW architectural registers, r0 = zero)
//   MD_LAT - E-stage occupancy of a multi-cycle op in cycles (legal 3..16)
//   FWD_EN - 1: forwarding mode, 0: stall-only mode
//   CNT_W  - width of the performance counters
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   rs1D, rs2D, useRs1D, useRs2D - decode-stage sources and "operand read" flags
//   rs1E, rs2E                   - execute-stage sources (forwarding targets)
//   rdE, rdM, rdW                - destination registers in E, M, W
//   regwriteE/M/W                - destination write enables in E, M, W
//   wbselE                       - E-stage writeback select (00 = load)
//   pcselE                       - branch/jump taken in E
//   mdE                          - E-stage instruction is multi-cycle
//   stallF, stallD, stallE       - stage stalls
//   flushD, flushE               - stage flushes (bubble insertion)
//   forwardAE, forwardBE         - 10 = from M, 01 = from W, 00 = register file
//   md_busy, md_done             - multi-cycle unit occupied / completion pulse
//   stall_cnt, flush_cnt         - saturating counts of stallD / flushD cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1D,
  input  logic [AW-1:0]    rs2D,
  input  logic             useRs1D,
  input  logic             useRs2D,
  input  logic [AW-1:0]    rs1E,
  input  logic [AW-1:0]    rs2E,
  input  logic [AW-1:0]    rdE,
  input  logic [AW-1:0]    rdM,
  input  logic [AW-1:0]    rdW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       wbselE,
  input  logic             pcselE,
  input  logic             mdE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 3);

  // ---------------------------------------------------------------------------
  // Forwarding. A destination of r0 never matches, so r0 always reads the
  // register file. M is younger than W and therefore wins.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] fwd_rs [2];
  logic [1:0]    fwd_sel [2];

  assign fwd_rs[0] = rs1E;
  assign fwd_rs[1] = rs2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      fwd_sel[gi] = 2'b00;
      if (regwriteM && (rdM != '0) && (rdM == fwd_rs[gi])) begin
        fwd_sel[gi] = 2'b10;
      end else if (regwriteW && (rdW != '0) && (rdW == fwd_rs[gi])) begin
        fwd_sel[gi] = 2'b01;
      end
    end
  end

  // In stall-only mode every producer is waited out in decode, so the muxes
  // stay on the register file. Reset also parks them there.
  assign forwardAE = (FWD_EN != 0 && !rst) ? fwd_sel[0] : 2'b00;
  assign forwardBE = (FWD_EN != 0 && !rst) ? fwd_sel[1] : 2'b00;

  // ---------------------------------------------------------------------------
  // Decode hazard. With forwarding only a load in E is unresolvable (its data
  // is not available until M completes); without forwarding any in-flight
  // writer of a source register blocks decode.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] dec_rs  [2];
  logic          dec_use [2];
  logic          src_haz [2];
  logic          load_e;
  logic          haz_D;

  assign dec_rs[0]  = rs1D;
  assign dec_rs[1]  = rs2D;
  assign dec_use[0] = useRs1D;
  assign dec_use[1] = useRs2D;
  assign load_e     = regwriteE && (wbselE == 2'b00);

  for (genvar gi = 0; gi < 2; gi++) begin : g_haz
    logic hit_e;
    logic hit_e_load;
    logic hit_m;
    logic hit_w;

    assign hit_e      = regwriteE && (rdE != '0) && (rdE == dec_rs[gi]);
    assign hit_e_load = load_e    && (rdE != '0) && (rdE == dec_rs[gi]);
    assign hit_m      = regwriteM && (rdM != '0) && (rdM == dec_rs[gi]);
    assign hit_w      = regwriteW && (rdW != '0) && (rdW == dec_rs[gi]);

    assign src_haz[gi] = dec_use[gi] &&
                         ((FWD_EN != 0) ? hit_e_load : (hit_e || hit_m || hit_w));
  end

  assign haz_D = src_haz[0] || src_haz[1];

  // ---------------------------------------------------------------------------
  // Multi-cycle occupancy FSM. The IDLE cycle that accepts the op counts as
  // the first stalled cycle, BUSY covers MD_LAT-2 cycles (counter MD_LAT-3
  // down to 0 inclusive) and DONE is the final, non-stalled cycle in which
  // the result leaves E, giving MD_LAT cycles in total.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  md_state_t  state_reg;
  logic [3:0] md_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      md_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mdE) begin
            md_cnt_reg <= MD_LOAD;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          if (md_cnt_reg == 4'd0) begin
            state_reg <= DONE;
          end else begin
            md_cnt_reg <= md_cnt_reg - 4'd1;
          end
        end
        DONE: begin
          // mdE still shows the completing op here; it must not retrigger.
          state_reg <= IDLE;
        end
        default: begin
          state_reg  <= IDLE;
          md_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

  logic md_stall;

  assign md_stall = ((state_reg == IDLE) && mdE) || (state_reg == BUSY);
  assign md_busy  = (state_reg != IDLE);
  assign md_done  = !rst && (state_reg == DONE);

  // ---------------------------------------------------------------------------
  // Stall / flush priority: reset > multi-cycle stall > taken branch > decode
  // hazard. While E is frozen the branch in E has not resolved yet, so it
  // must not flush; a taken branch kills the hazarding decode instruction,
  // so stalling it would be pointless.
  // ---------------------------------------------------------------------------
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (md_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
    end else if (pcselE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (haz_D) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stallD && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flushD && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Two instances share one stimulus bus: "dut" (forwarding, MD_LAT=4, 2-bit
// counters so saturation is reachable) and "dut_so" (stall-only, MD_LAT=3).
// Each cycle a stimulus vector and its expected output vector are pushed; the
// expectation is popped and compared a few ns later, before the next rising
// edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       useRs1D, useRs2D, regwriteE, regwriteM, regwriteW, pcselE, mdE;
  logic [1:0] wbselE;

  logic       stallF, stallD, stallE, flushD, flushE, md_busy, md_done;
  logic [1:0] forwardAE, forwardBE, stall_cnt, flush_cnt;

  logic       so_stallF, so_stallD, so_stallE, so_flushD, so_flushE, so_md_busy, so_md_done;
  logic [1:0] so_forwardAE, so_forwardBE;
  logic [7:0] so_stall_cnt, so_flush_cnt;

  hazard_scoreboard #(.AW(5), .MD_LAT(4), .FWD_EN(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .wbselE(wbselE), .pcselE(pcselE), .mdE(mdE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scoreboard #(.AW(5), .MD_LAT(3), .FWD_EN(0), .CNT_W(8)) dut_so (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .wbselE(wbselE), .pcselE(pcselE), .mdE(mdE),
    .stallF(so_stallF), .stallD(so_stallD), .stallE(so_stallE),
    .flushD(so_flushD), .flushE(so_flushE),
    .forwardAE(so_forwardAE), .forwardBE(so_forwardBE),
    .md_busy(so_md_busy), .md_done(so_md_done),
    .stall_cnt(so_stall_cnt), .flush_cnt(so_flush_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D;
    logic       useRs1D, useRs2D;
    logic [4:0] rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteE, regwriteM, regwriteW;
    logic [1:0] wbselE;
    logic       pcselE, mdE;
  } stim_t;

  // ctl = {stallF, stallD, stallE, flushD, flushE}
  typedef struct packed {
    logic [4:0] ctl;
    logic [1:0] fa, fb;
    logic       busy, done;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t mk(input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic busy, input logic done);
    obs_t o;
    o.ctl = ctl; o.fa = fa; o.fb = fb; o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic obs_t sample_main();
    return mk({stallF, stallD, stallE, flushD, flushE}, forwardAE, forwardBE, md_busy, md_done);
  endfunction

  function automatic obs_t sample_so();
    return mk({so_stallF, so_stallD, so_stallE, so_flushD, so_flushE},
              so_forwardAE, so_forwardBE, so_md_busy, so_md_done);
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.wbselE = 2'b01;
    return s;
  endfunction

  function automatic stim_t load_use7();
    stim_t s;
    s = nop();
    s.wbselE = 2'b00; s.regwriteE = 1'b1; s.rdE = 5'd7; s.rs2D = 5'd7; s.useRs2D = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; useRs1D = s.useRs1D; useRs2D = s.useRs2D;
    rs1E = s.rs1E; rs2E = s.rs2E; rdE = s.rdE; rdM = s.rdM; rdW = s.rdW;
    regwriteE = s.regwriteE; regwriteM = s.regwriteM; regwriteW = s.regwriteW;
    wbselE = s.wbselE; pcselE = s.pcselE; mdE = s.mdE;
  endtask

  // Drive one cycle of stimulus just after the falling edge and queue its
  // expectation; returns 2 ns later, well before the next rising edge.
  task automatic drive(input stim_t s, input obs_t e);
    @(negedge clk);
    apply(s);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic do_reset();
    stim_t s;
    s = nop();
    s.rst = 1'b1;
    @(negedge clk);
    apply(s);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    s = nop(); s.rst = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b00011, 2'b00, 2'b00, 1'b0, 1'b0));
    // Reset must override branch, hazard, multi-cycle and forwarding inputs.
    s = load_use7(); s.rst = 1'b1; s.pcselE = 1'b1; s.mdE = 1'b1;
    s.regwriteM = 1'b1; s.rdM = 5'd5; s.rs1E = 5'd5; s.rs2E = 5'd5;
    st.push_back(s); ex.push_back(mk(5'b00011, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] reset[%0d] ok %b", i, got);
    end
    n_tests++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt: got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_forwarding();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    do_reset();
    s = nop(); s.regwriteM = 1'b1; s.rdM = 5'd5; s.rs1E = 5'd5; s.regwriteW = 1'b1; s.rdW = 5'd5;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b10, 2'b00, 1'b0, 1'b0));
    s.rdM = 5'd0;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b01, 2'b00, 1'b0, 1'b0));
    s = nop(); s.regwriteM = 1'b1; s.regwriteW = 1'b1;   // all addresses r0
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.rs2E = 5'd9; s.rdM = 5'd9; s.regwriteW = 1'b1; s.rdW = 5'd9;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b01, 1'b0, 1'b0));
    s.regwriteM = 1'b1; s.rs1E = 5'd3;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b10, 1'b0, 1'b0));
    s = nop(); s.rs1E = 5'd12; s.rs2E = 5'd12; s.regwriteW = 1'b1; s.rdW = 5'd12;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b01, 2'b01, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL fwd[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] fwd[%0d] ok %b", i, got);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    do_reset();
    st.push_back(load_use7()); ex.push_back(mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0));
    st.push_back(nop());       ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = load_use7(); s.rdE = 5'd0; s.rs2D = 5'd0;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = load_use7(); s.useRs2D = 1'b0; s.rs1D = 5'd7;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = load_use7(); s.wbselE = 2'b01;                   // ALU result is forwardable
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = load_use7(); s.rs2D = 5'd0; s.rs1D = 5'd7; s.useRs1D = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL load_use[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] load_use[%0d] ok %b", i, got);
      if (i == 1) begin
        n_tests++;
        if (stall_cnt !== 2'd1) begin
          n_fail++; $display("FAIL load_use_cnt: got=%0d exp=1", stall_cnt);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_multicycle();
    stim_t s;
    obs_t  got, e;
    obs_t  pat[4];
    pat[0] = mk(5'b11100, 2'b00, 2'b00, 1'b0, 1'b0);
    pat[1] = mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0);
    pat[2] = mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0);
    pat[3] = mk(5'b00000, 2'b00, 2'b00, 1'b1, 1'b1);
    do_reset();
    s = nop(); s.mdE = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) s.mdE = 1'b0;
      drive(s, (i == 8) ? mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0) : pat[i % 4]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL md[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] md[%0d] ok %b", i, got);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    do_reset();
    s = load_use7(); s.pcselE = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b00011, 2'b00, 2'b00, 1'b0, 1'b0));
    s.mdE = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b0, 1'b0));
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0));
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0));
    s.mdE = 1'b0;
    st.push_back(s); ex.push_back(mk(5'b00011, 2'b00, 2'b00, 1'b1, 1'b1));
    st.push_back(nop()); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL prio[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] prio[%0d] ok %b", i, got);
    end
    n_tests++;
    if (flush_cnt !== 2'd2 || stall_cnt !== 2'd3) begin
      n_fail++; $display("FAIL prio_cnt: got=%0d/%0d exp=2/3", flush_cnt, stall_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_busy();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    do_reset();
    s = nop(); s.mdE = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b0, 1'b0));
    st.push_back(nop()); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0));
    s = nop(); s.rst = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b00011, 2'b00, 2'b00, 1'b1, 1'b0));
    st.push_back(nop()); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL rst_busy[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] rst_busy[%0d] ok %b", i, got);
      if (i == 2) begin
        n_tests++;
        if (stall_cnt !== 2'd2) begin
          n_fail++; $display("FAIL rst_busy_pre_cnt: got=%0d exp=2", stall_cnt);
        end
      end
    end
    n_tests++;
    if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
      n_fail++; $display("FAIL rst_busy_cnt: got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    obs_t got, e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive((i < 5) ? load_use7() : nop(),
            (i < 5) ? mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0) : mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
      got = sample_main(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL sat[%0d]: got=%b exp=%b", i, got, e);
      end
      n_tests++;
      if (stall_cnt !== 2'((i > 3) ? 3 : i)) begin
        n_fail++; $display("FAIL sat_cnt[%0d]: got=%0d exp=%0d", i, stall_cnt, (i > 3) ? 3 : i);
      end else $display("[TB] sat[%0d] stall_cnt=%0d", i, stall_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_only();
    stim_t st[$];
    obs_t  ex[$];
    stim_t s;
    obs_t  got, e;
    do_reset();
    s = nop(); s.regwriteW = 1'b1; s.rdW = 5'd3; s.rs1D = 5'd3; s.useRs1D = 1'b1; s.rs1E = 5'd3;
    st.push_back(s); ex.push_back(mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.regwriteM = 1'b1; s.rdM = 5'd6; s.rs2D = 5'd6; s.useRs2D = 1'b1; s.rs2E = 5'd6;
    st.push_back(s); ex.push_back(mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.regwriteE = 1'b1; s.rdE = 5'd4; s.rs1D = 5'd4; s.useRs1D = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b11001, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.regwriteW = 1'b1; s.useRs1D = 1'b1;     // r0 never hazards
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.rdW = 5'd3; s.rs1D = 5'd3; s.useRs1D = 1'b1;
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    s = nop(); s.mdE = 1'b1;                              // MD_LAT=3: one BUSY cycle
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b0, 1'b0));
    st.push_back(s); ex.push_back(mk(5'b11100, 2'b00, 2'b00, 1'b1, 1'b0));
    st.push_back(s); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b1, 1'b1));
    st.push_back(nop()); ex.push_back(mk(5'b00000, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i], ex[i]);
      got = sample_so(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL stall_only[%0d]: got=%b exp=%b", i, got, e);
      end else $display("[TB] stall_only[%0d] ok %b", i, got);
    end
    n_tests++;
    if (so_stall_cnt !== 8'd5) begin
      n_fail++; $display("FAIL stall_only_cnt: got=%0d exp=5", so_stall_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    stim_t s0;
    s0 = nop();
    s0.rst = 1'b1;
    apply(s0);
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_priority();
    test_reset_mid_busy();
    test_saturation();
    test_stall_only();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width (2^AW architectural registers).
REQ-002 SHALL have parameter MD_LAT, default 4, multi-cycle (mul/div) E-stage occupancy in cycles, legal range 3..16.
REQ-003 SHALL have parameter FWD_EN, default 1, 1 = forwarding mode, 0 = stall-only mode.
REQ-004 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-005 SHALL have ports in this order: clk in 1, single clock, all state on rising edge; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports rs1D, rs2D in AW, decode-stage source registers; useRs1D, useRs2D in 1, decode operand actually read.
REQ-007 SHALL have ports rs1E, rs2E, rdE, rdM, rdW in AW, stage register addresses.
REQ-008 SHALL have ports regwriteE, regwriteM, regwriteW in 1; wbselE in 2 (00 = load); pcselE in 1, branch/jump taken; mdE in 1, E-stage instruction is multi-cycle.
REQ-009 SHALL have outputs stallF, stallD, stallE, flushD, flushE in 1; forwardAE, forwardBE out 2; md_busy, md_done out 1; stall_cnt, flush_cnt out CNT_W.

Function
REQ-010 SHALL never detect a hazard or forward on register 0.
REQ-011 SHALL, with FWD_EN=1, drive forwardAE = 10 if regwriteM and rdM==rs1E, else 01 if regwriteW and rdW==rs1E, else 00; forwardBE identical on rs2E; M wins over W.
REQ-012 SHALL, with FWD_EN=0, hold forwardAE/BE at 00.
REQ-013 SHALL flag decode hazard haz_D when (useRs1D and rs1D match) or (useRs2D and rs2D match) against: FWD_EN=1, rdE with regwriteE and wbselE==00; FWD_EN=0, any of rdE/rdM/rdW with its regwrite.
REQ-014 SHALL keep multi-cycle FSM with states IDLE, BUSY, DONE and down-counter of width 4.
REQ-015 SHALL, in IDLE with mdE=1, assert stallE, load counter with MD_LAT-3, go BUSY; with MD_LAT=3 BUSY lasts exactly one cycle.
REQ-016 SHALL, in BUSY, assert stallE and decrement counter; at counter 0 go DONE.
REQ-017 SHALL, in DONE, deassert stallE, pulse md_done for one cycle, ignore mdE, go IDLE; total E occupancy = MD_LAT cycles; back-to-back md ops restart from IDLE.
REQ-018 SHALL drive md_busy = (state != IDLE).
REQ-019 SHALL assert stallF and stallD whenever stallE=1; flushE=0 and flushD=0 while stallE=1 (pcselE and haz_D ignored).
REQ-020 SHALL, when stallE=0 and pcselE=1, assert flushD=1, flushE=1, stallF=0, stallD=0 (branch overrides haz_D).
REQ-021 SHALL, when stallE=0, pcselE=0, haz_D=1, assert stallF=1, stallD=1, flushE=1, flushD=0.
REQ-022 SHALL otherwise drive all stall/flush outputs 0; all stall, flush, forward outputs combinational from inputs and FSM state.
REQ-023 SHALL increment stall_cnt each cycle stallD=1 and flush_cnt each cycle flushD=1, both saturating at all-ones.

Reset
REQ-024 SHALL, on clk edge with rst=1, set FSM IDLE, counter 0, stall_cnt 0, flush_cnt 0, including mid-BUSY.
REQ-025 SHALL, while rst=1, force flushD=1, flushE=1, stallF/D/E=0, forwardAE/BE=00, md_done=0.

Verification
REQ-026 SHALL cover forwarding: FWD_EN=1, regwriteM=1, rdM=rs1E=5, regwriteW=1, rdW=5 -> forwardAE=10; rdM=0 -> forwardAE=01.
REQ-027 SHALL cover load-use: wbselE=00, regwriteE=1, rdE=rs2D=7, useRs2D=1 -> stallF=stallD=flushE=1 one cycle, stall_cnt +1; rdE=0 -> no stall.
REQ-028 SHALL cover multi-cycle: MD_LAT=4, mdE=1 held -> stallE=1 for 3 cycles, md_done=1 on 4th, then IDLE; mdE=1 again -> repeats.
REQ-029 SHALL cover priority: pcselE=1 with haz_D=1 -> flushD=flushE=1, stalls 0; same during BUSY -> stalls 1, flushes 0.
REQ-030 SHALL cover reset mid-BUSY and saturation: rst=1 in BUSY -> next cycle IDLE, counters 0; CNT_W=2 with 5 stall cycles -> stall_cnt=3.
REQ-031 SHALL cover stall-only mode: FWD_EN=0, regwriteW=1, rdW=rs1D=3, useRs1D=1 -> stallD=1, forwardAE=00.
